// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/forward sequencer for the 5-stage MIPS pipeline.
//   Drives the PC enable and the EN/CLR pair of every pipeline register.
//   Resolves load-use and branch-operand RAW hazards, control-transfer flushes
//   and multi-cycle data-memory waits.
//   Optional feature macro: HAZARD_PERF_CNT_EN (adds stall/flush/wait counters).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   rs_D, rt_D, rs_E, rt_E          source register indices in Decode / Execute
//   WriteReg_E/M/W, RegWrite_E/M/W  destination index and write enable per stage
//   MemtoReg_E/M                    load instruction in Execute / Memory
//   Branch_D, Jr_D, J_D, PCSrc_D    control transfer in Decode, branch taken
//   mem_req_M, mem_ready            data memory access request / completion
//   EN_PC, EN_FD, EN_DE, EN_EM, EN_MW  register enables
//   CLR_FD, CLR_DE, CLR_EM, CLR_MW     register clears (bubble insert)
//   ForwardA_E, ForwardB_E          00 regfile, 01 from W, 10 from M
//   ForwardA_D, ForwardB_D          forward ALU_result_M to the Decode comparator
//   mem_err                         sticky memory timeout flag
//   stall_cnt, flush_cnt, wait_cnt  performance counters (HAZARD_PERF_CNT_EN only)
module pipeline_hazard_controller #(
    parameter int WIDTH_5     = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH_5-1:0] rs_D,
    input  logic [WIDTH_5-1:0] rt_D,
    input  logic [WIDTH_5-1:0] rs_E,
    input  logic [WIDTH_5-1:0] rt_E,
    input  logic [WIDTH_5-1:0] WriteReg_E,
    input  logic [WIDTH_5-1:0] WriteReg_M,
    input  logic [WIDTH_5-1:0] WriteReg_W,
    input  logic               RegWrite_E,
    input  logic               RegWrite_M,
    input  logic               RegWrite_W,
    input  logic               MemtoReg_E,
    input  logic               MemtoReg_M,
    input  logic               Branch_D,
    input  logic               Jr_D,
    input  logic               J_D,
    input  logic               PCSrc_D,
    input  logic               mem_req_M,
    input  logic               mem_ready,
    output logic               EN_PC,
    output logic               EN_FD,
    output logic               EN_DE,
    output logic               EN_EM,
    output logic               EN_MW,
    output logic               CLR_FD,
    output logic               CLR_DE,
    output logic               CLR_EM,
    output logic               CLR_MW,
    output logic [1:0]         ForwardA_E,
    output logic [1:0]         ForwardB_E,
    output logic               ForwardA_D,
    output logic               ForwardB_D,
    output logic               mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
    output logic [31:0]        wait_cnt
`endif
);
    localparam int CW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic m_fwd_ok, w_fwd_ok, lwstall, e_hit, m_hit, brstall;
    logic wait_start, freeze, release_mw, stall, flush;

    assign m_fwd_ok = RegWrite_M && WriteReg_M != '0;
    assign w_fwd_ok = RegWrite_W && WriteReg_W != '0;

    assign lwstall = MemtoReg_E && RegWrite_E && WriteReg_E != '0 &&
                     (WriteReg_E == rs_D || WriteReg_E == rt_D);
    // Jr only reads rs, so rt is compared for conditional branches alone.
    assign e_hit   = RegWrite_E && WriteReg_E != '0 &&
                     (WriteReg_E == rs_D || (Branch_D && WriteReg_E == rt_D));
    assign m_hit   = MemtoReg_M && WriteReg_M != '0 &&
                     (WriteReg_M == rs_D || (Branch_D && WriteReg_M == rt_D));
    assign brstall = (Branch_D || Jr_D) && (e_hit || m_hit);

    // A memory wait freezes the front of the pipe and overrides stall/flush.
    assign wait_start = state == RUN && mem_req_M && !mem_ready;
    assign freeze     = state != RUN || wait_start;
    assign release_mw = state == MEM_WAIT && mem_ready;
    assign stall      = !freeze && (lwstall || brstall);
    assign flush      = !freeze && !stall && (PCSrc_D || J_D || Jr_D);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: if (mem_req_M && !mem_ready) begin
                state_nx = MEM_WAIT;
                cnt_nx   = CW'(1);
            end
            MEM_WAIT: if (mem_ready) begin
                state_nx = RUN;
                cnt_nx   = '0;
            end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                state_nx = ERR;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        EN_PC      = !freeze && !stall;
        EN_FD      = !freeze && !stall;
        EN_DE      = !freeze;
        EN_EM      = !freeze;
        EN_MW      = !freeze || release_mw;
        CLR_FD     = flush;
        CLR_DE     = stall;
        CLR_EM     = 1'b0;
        CLR_MW     = freeze && !release_mw;
        ForwardA_E = (m_fwd_ok && WriteReg_M == rs_E) ? 2'b10 :
                     (w_fwd_ok && WriteReg_W == rs_E) ? 2'b01 : 2'b00;
        ForwardB_E = (m_fwd_ok && WriteReg_M == rt_E) ? 2'b10 :
                     (w_fwd_ok && WriteReg_W == rt_E) ? 2'b01 : 2'b00;
        ForwardA_D = m_fwd_ok && WriteReg_M == rs_D;
        ForwardB_D = m_fwd_ok && WriteReg_M == rt_D;
        mem_err    = state == ERR;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            stall_cnt <= stall_cnt + 32'(stall);
            flush_cnt <= flush_cnt + 32'(flush);
            wait_cnt  <= wait_cnt + 32'(state == MEM_WAIT);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: scoreboard bench for pipeline_hazard_controller (MEM_TIMEOUT=4).
module tb_pipeline_hazard_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic       RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
    logic       Branch_D, Jr_D, J_D, PCSrc_D, mem_req_M, mem_ready;
    logic       EN_PC, EN_FD, EN_DE, EN_EM, EN_MW, CLR_FD, CLR_DE, CLR_EM, CLR_MW;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic       ForwardA_D, ForwardB_D, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
    logic [95:0] cnt_q[$];
`endif

    pipeline_hazard_controller #(.WIDTH_5(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
        .Branch_D(Branch_D), .Jr_D(Jr_D), .J_D(J_D), .PCSrc_D(PCSrc_D),
        .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .EN_PC(EN_PC), .EN_FD(EN_FD), .EN_DE(EN_DE), .EN_EM(EN_EM), .EN_MW(EN_MW),
        .CLR_FD(CLR_FD), .CLR_DE(CLR_DE), .CLR_EM(CLR_EM), .CLR_MW(CLR_MW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Packed view: {EN_PC,FD,DE,EM,MW, CLR_FD,DE,EM,MW, FwdA_E, FwdB_E, FwdA_D, FwdB_D, mem_err}
    localparam logic [15:0] IDLE  = 16'b11111_0000_00_00_0_0_0;
    localparam logic [15:0] STALL = 16'b00111_0100_00_00_0_0_0;
    localparam logic [15:0] FLUSH = 16'b11111_1000_00_00_0_0_0;
    localparam logic [15:0] FRZ   = 16'b00000_0001_00_00_0_0_0;
    localparam logic [15:0] REL   = 16'b00001_0000_00_00_0_0_0;
    localparam logic [15:0] ERRV  = 16'b00000_0001_00_00_0_0_1;

    logic [15:0] act, e;
    string       n;
    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    assign act = {EN_PC, EN_FD, EN_DE, EN_EM, EN_MW, CLR_FD, CLR_DE, CLR_EM, CLR_MW,
                  ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D, mem_err};

    function automatic logic [15:0] mk(input logic [4:0] en, input logic [3:0] clr,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic fad, input logic fbd, input logic err);
        return {en, clr, fa, fb, fad, fbd, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        {rs_D, rt_D, rs_E, rt_E, WriteReg_E, WriteReg_M, WriteReg_W} = '0;
        {RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M} = '0;
        {Branch_D, Jr_D, J_D, PCSrc_D, mem_req_M, mem_ready} = '0;
    endtask

    task automatic chk(input string nm, input logic [15:0] ev);
        exp_q.push_back(ev);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b want %b", n, act, e);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        if (cnt_q.size() != 0) begin
            checks++;
            if ({stall_cnt, flush_cnt, wait_cnt} !== cnt_q[0]) begin
                errors++;
                $display("FAIL perf_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                         stall_cnt, flush_cnt, wait_cnt,
                         cnt_q[0][95:64], cnt_q[0][63:32], cnt_q[0][31:0]);
            end
            void'(cnt_q.pop_front());
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_idle", IDLE);
        // T1 load-use
        tick(); MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 5; rs_D = 5; chk("t1_lwstall", STALL);
        tick(); rs_D = 5; MemtoReg_M = 1; RegWrite_M = 1; WriteReg_M = 5;
        chk("t1_lw_in_m", mk(5'b11111, 4'b0000, 2'b00, 2'b00, 1, 0, 0));
        tick(); rs_E = 5; RegWrite_W = 1; WriteReg_W = 5;
        chk("t1_fwd_w", mk(5'b11111, 4'b0000, 2'b01, 2'b00, 0, 0, 0));
        tick(); MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 0; rs_D = 0; chk("t1_reg0_nostall", IDLE);
        tick(); MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 6; rt_D = 6; chk("t1_lwstall_rt", STALL);
        // T2 forwarding into Execute
        tick(); RegWrite_M = 1; RegWrite_W = 1; WriteReg_M = 8; WriteReg_W = 8; rs_E = 8;
        chk("t2_m_beats_w", mk(5'b11111, 4'b0000, 2'b10, 2'b00, 0, 0, 0));
        tick(); RegWrite_M = 1; RegWrite_W = 1; WriteReg_M = 0; WriteReg_W = 8; rs_E = 8;
        chk("t2_from_w", mk(5'b11111, 4'b0000, 2'b01, 2'b00, 0, 0, 0));
        tick(); RegWrite_M = 1; RegWrite_W = 1; chk("t2_reg0", IDLE);
        tick(); RegWrite_M = 1; WriteReg_M = 8; rt_E = 8; rt_D = 8;
        chk("t2_fwd_b_m", mk(5'b11111, 4'b0000, 2'b00, 2'b10, 0, 1, 0));
        tick(); WriteReg_M = 8; RegWrite_W = 1; WriteReg_W = 8; rt_E = 8;
        chk("t2_fwd_b_w", mk(5'b11111, 4'b0000, 2'b00, 2'b01, 0, 0, 0));
        // T3 control transfer
        tick(); Branch_D = 1; PCSrc_D = 1; rs_D = 3; rt_D = 4; chk("t3_flush", FLUSH);
        tick(); Branch_D = 1; PCSrc_D = 1; rs_D = 3; rt_D = 4; RegWrite_E = 1; WriteReg_E = 3;
        chk("t3_brstall_beats_flush", STALL);
        tick(); Branch_D = 1; rt_D = 4; RegWrite_E = 1; WriteReg_E = 4; chk("t3_brstall_rt", STALL);
        tick(); Jr_D = 1; rs_D = 2; rt_D = 7; RegWrite_E = 1; WriteReg_E = 7; chk("t3_jr_ignores_rt", FLUSH);
        tick(); Branch_D = 1; rs_D = 9; MemtoReg_M = 1; RegWrite_M = 1; WriteReg_M = 9;
        chk("t3_brstall_load_m", mk(5'b00111, 4'b0100, 2'b00, 2'b00, 1, 0, 0));
        tick(); J_D = 1; chk("t3_jump_flush", FLUSH);
        // T4 memory wait
        tick(); mem_req_M = 1; chk("t4_wait1", FRZ);
        tick(); mem_req_M = 1; MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 5; rs_D = 5; PCSrc_D = 1;
        chk("t4_wait2_masked", FRZ);
        tick(); mem_req_M = 1; chk("t4_wait3", FRZ);
        tick(); mem_req_M = 1; mem_ready = 1; chk("t4_release", REL);
        tick(); Branch_D = 1; PCSrc_D = 1; chk("t4_run_after", FLUSH);
        tick(); mem_req_M = 1; mem_ready = 1; chk("t4_single_cycle", IDLE);
        // release on the last cycle before timeout
        tick(); mem_req_M = 1; chk("wait_edge1", FRZ);
        tick(); mem_req_M = 1; chk("wait_edge2", FRZ);
        tick(); mem_req_M = 1; chk("wait_edge3", FRZ);
        tick(); mem_req_M = 1; mem_ready = 1; chk("wait_edge_release", REL);
        tick(); chk("wait_edge_idle", IDLE);
        // T5 timeout
        for (int i = 0; i < 4; i++) begin
            tick(); mem_req_M = 1; chk("t5_freeze", FRZ);
        end
        tick(); mem_req_M = 1; chk("t5_err", ERRV);
        tick(); chk("t5_err_sticky", ERRV);
        tick(); mem_req_M = 1; mem_ready = 1; chk("t5_err_ignores_ready", ERRV);
        tick(); rst_n = 0; chk("t5_rst_cycle", ERRV);
        tick(); rst_n = 1; chk("t5_after_reset", IDLE);
        // reset in the middle of a wait
        tick(); mem_req_M = 1; chk("midwait_freeze", FRZ);
        tick(); rst_n = 0; chk("midwait_rst_cycle", FRZ);
        tick(); rst_n = 1; chk("midwait_after_reset", IDLE);
`ifdef HAZARD_PERF_CNT_EN
        tick(); rst_n = 0;
        tick(); rst_n = 1; MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 5; rs_D = 5; chk("t6_stall", STALL);
        tick(); Branch_D = 1; PCSrc_D = 1; rs_D = 3; chk("t6_flush", FLUSH);
        tick(); Branch_D = 1; PCSrc_D = 1; rs_D = 3; RegWrite_E = 1; WriteReg_E = 3; chk("t6_brstall", STALL);
        for (int i = 0; i < 3; i++) begin
            tick(); mem_req_M = 1; chk("t6_wait", FRZ);
        end
        tick(); mem_req_M = 1; mem_ready = 1; chk("t6_release", REL);
        tick(); chk("t6_idle", IDLE); cnt_q.push_back({32'd2, 32'd1, 32'd3});
`endif
        tick();
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
